// File: rtl/me_ctrl_pkg.sv
// Shared types and sizing helpers for the motion-estimation search controller.
package me_ctrl_pkg;

  // Spare encodings fall back to StInit.
  typedef enum logic [2:0] {
    StInit = 3'd0,
    StIdle = 3'd1,
    StRun  = 3'd2,
    StDone = 3'd3
  } me_state_e;

  // Enable windows open this many cycles after the cycle that samples req.
  localparam int unsigned AddrStart   = 2;
  localparam int unsigned PeSwStart   = 3;

  function automatic int unsigned vec_width(input int unsigned sw, input int unsigned tb);
    return $clog2(sw - tb + 1);
  endfunction

  function automatic int unsigned cand_count(input int unsigned sw, input int unsigned tb);
    return (sw - tb + 1) * (sw - tb + 1);
  endfunction

  function automatic int unsigned addr_sw_len(input int unsigned sw);
    return sw * sw;
  endfunction

  function automatic int unsigned addr_tb_len(input int unsigned tb);
    return tb * tb;
  endfunction

  function automatic int unsigned pe_sw_len(input int unsigned sw, input int unsigned tb);
    return sw * sw + sw - tb;
  endfunction

endpackage

// File: rtl/me_phase_window.sv
// Registered enable that is high for LEN cycles, starting START cycles after the go cycle.
module me_phase_window #(
  parameter int unsigned START = 1,
  parameter int unsigned LEN   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic kill,
  output logic en
);

  localparam int unsigned EndCnt = START + LEN;
  localparam int unsigned CntW   = $clog2(EndCnt + 1);
  localparam logic [CntW-1:0] StartC = CntW'(START);
  localparam logic [CntW-1:0] EndC   = CntW'(EndCnt);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            en_q, en_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (kill) begin
      run_d = 1'b0;
    end else if (go) begin
      run_d = 1'b1;
      cnt_d = CntW'(1);
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == EndC) run_d = 1'b0;
    end
    en_d = run_d && (cnt_d >= StartC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      en_q  <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search ME controller: sequences address generators / PE array, scans candidates,
// tracks the minimum SAD and its vector, and handshakes results with the host.
module me_search_ctrl
  import me_ctrl_pkg::*;
#(
  parameter int unsigned SAD_WIDTH  = 16,
  parameter int unsigned TB_LENGTH  = 16,
  parameter int unsigned SW_LENGTH  = 64,
  parameter int unsigned PIPE_DELAY = SW_LENGTH - TB_LENGTH + 7,
  parameter int unsigned TIE_MODE   = 0,
  localparam int unsigned VEC_WIDTH = vec_width(SW_LENGTH, TB_LENGTH),
  localparam int unsigned CNT_WIDTH = $clog2(cand_count(SW_LENGTH, TB_LENGTH) + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 abort,
  input  logic [SAD_WIDTH-1:0] sad,
  output logic                 clr,
  output logic                 en_addr_sw,
  output logic                 en_addr_tb,
  output logic                 en_pearray_sw,
  output logic                 en_pearray_tb,
  output logic [SAD_WIDTH-1:0] min_sad,
  output logic [VEC_WIDTH-1:0] min_mvx,
  output logic [VEC_WIDTH-1:0] min_mvy,
  output logic [CNT_WIDTH-1:0] cand_cnt,
  output logic                 aborted,
  output logic                 ack
);

  localparam int unsigned ScanW = $clog2(SW_LENGTH);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SW_LENGTH - 1);
  localparam logic [ScanW-1:0] ValidMin = ScanW'(TB_LENGTH - 1);
  localparam int unsigned WaitW = (PIPE_DELAY > 0) ? $clog2(PIPE_DELAY + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(PIPE_DELAY);

  me_state_e state_q, state_d;
  logic      go, run_exit, abort_run;

  logic [WaitW-1:0] wait_q;
  logic             scan_pend_q, scan_on_q, scan_last_q;
  logic [ScanW-1:0] scan_x_q, scan_y_q;

  logic                 valid, better, upd;
  logic [SAD_WIDTH-1:0] min_sad_q;
  logic [VEC_WIDTH-1:0] min_mvx_q, min_mvy_q;
  logic [CNT_WIDTH-1:0] cand_cnt_q;
  logic                 aborted_q, en_pearray_tb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StInit;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    ack     = 1'b0;
    case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        clr = 1'b1;
        if (req) state_d = StRun;
      end
      StRun: if (abort || scan_last_q) state_d = StDone;
      StDone: begin
        ack = 1'b1;
        if (!req) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  assign go        = (state_q == StIdle) && req;
  assign abort_run = (state_q == StRun) && abort;
  assign run_exit  = (state_q == StRun) && (abort || scan_last_q);

  me_phase_window #(
    .START(AddrStart),
    .LEN  (addr_sw_len(SW_LENGTH))
  ) u_win_addr_sw (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go),
    .kill (run_exit),
    .en   (en_addr_sw)
  );

  me_phase_window #(
    .START(AddrStart),
    .LEN  (addr_tb_len(TB_LENGTH))
  ) u_win_addr_tb (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go),
    .kill (run_exit),
    .en   (en_addr_tb)
  );

  me_phase_window #(
    .START(PeSwStart),
    .LEN  (pe_sw_len(SW_LENGTH, TB_LENGTH))
  ) u_win_pearray_sw (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go),
    .kill (run_exit),
    .en   (en_pearray_sw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_pearray_tb_q <= 1'b0;
    else        en_pearray_tb_q <= en_addr_tb && !run_exit;
  end

  assign en_pearray_tb = en_pearray_tb_q;

  // Pipeline wait, then raster scan with scan_y as the inner index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q      <= '0;
      scan_pend_q <= 1'b0;
      scan_on_q   <= 1'b0;
      scan_last_q <= 1'b0;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
    end else if (go) begin
      wait_q      <= '0;
      scan_pend_q <= 1'b1;
      scan_on_q   <= 1'b0;
      scan_last_q <= 1'b0;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
    end else if (run_exit) begin
      scan_pend_q <= 1'b0;
      scan_on_q   <= 1'b0;
      scan_last_q <= 1'b0;
    end else if (state_q == StRun) begin
      if (scan_pend_q) begin
        if (wait_q == WaitLast) begin
          scan_pend_q <= 1'b0;
          scan_on_q   <= 1'b1;
          scan_x_q    <= '0;
          scan_y_q    <= '0;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
      end
      if (scan_on_q) begin
        if (scan_y_q == ScanLast) begin
          scan_y_q <= '0;
          if (scan_x_q == ScanLast) begin
            scan_x_q    <= '0;
            scan_on_q   <= 1'b0;
            scan_last_q <= 1'b1;
          end else begin
            scan_x_q <= scan_x_q + 1'b1;
          end
        end else begin
          scan_y_q <= scan_y_q + 1'b1;
        end
      end
    end
  end

  assign valid  = scan_on_q && (scan_x_q >= ValidMin) && (scan_y_q >= ValidMin);
  assign better = (TIE_MODE != 0) ? (sad <= min_sad_q) : (sad < min_sad_q);
  // The candidate presented in the abort cycle is not taken.
  assign upd    = (state_q == StRun) && valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_sad_q  <= '1;
      min_mvx_q  <= '0;
      min_mvy_q  <= '0;
      cand_cnt_q <= '0;
      aborted_q  <= 1'b0;
    end else if (go) begin
      min_sad_q  <= '1;
      min_mvx_q  <= '0;
      min_mvy_q  <= '0;
      cand_cnt_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      if (upd) begin
        cand_cnt_q <= cand_cnt_q + 1'b1;
        if (better) begin
          min_sad_q <= sad;
          min_mvx_q <= VEC_WIDTH'(scan_x_q - ValidMin);
          min_mvy_q <= VEC_WIDTH'(scan_y_q - ValidMin);
        end
      end
      if (abort_run) aborted_q <= 1'b1;
    end
  end

  assign min_sad  = min_sad_q;
  assign min_mvx  = min_mvx_q;
  assign min_mvy  = min_mvy_q;
  assign cand_cnt = cand_cnt_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed + randomized bench for me_search_ctrl: 8/4 controllers (both tie rules) and a
// default-size 64/16 controller, checked against a candidate-level reference model.
module tb_me_search_ctrl;

  localparam int SW    = 8;
  localparam int TB    = 4;
  localparam int PD    = 11;
  localparam int N     = SW - TB + 1;
  localparam int VW    = $clog2(N);
  localparam int CW    = $clog2(N * N + 1);
  localparam int SWL   = 64;
  localparam int TBL   = 16;
  localparam int PDL   = SWL - TBL + 7;
  localparam int NL    = SWL - TBL + 1;
  localparam int VWL   = $clog2(NL);
  localparam int CWL   = $clog2(NL * NL + 1);
  localparam int Never = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic          rst_n, req, abort;
  logic [15:0]   sad;
  logic          clr0, eas0, eat0, eps0, ept0, ab0, ack0;
  logic [15:0]   ms0;
  logic [VW-1:0] mx0, my0;
  logic [CW-1:0] cc0;
  logic          clr1, eas1, eat1, eps1, ept1, ab1, ack1;
  logic [15:0]   ms1;
  logic [VW-1:0] mx1, my1;
  logic [CW-1:0] cc1;

  logic           rst_nl, req_l, abort_l;
  logic [15:0]    sad_l;
  logic           clrl, easl, eatl, epsl, eptl, abl, ackl;
  logic [15:0]    msl;
  logic [VWL-1:0] mxl, myl;
  logic [CWL-1:0] ccl;

  int tab_l[SWL*SWL];

  me_search_ctrl #(
    .SAD_WIDTH(16), .TB_LENGTH(TB), .SW_LENGTH(SW), .PIPE_DELAY(PD), .TIE_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .abort(abort), .sad(sad), .clr(clr0),
    .en_addr_sw(eas0), .en_addr_tb(eat0), .en_pearray_sw(eps0), .en_pearray_tb(ept0),
    .min_sad(ms0), .min_mvx(mx0), .min_mvy(my0), .cand_cnt(cc0), .aborted(ab0), .ack(ack0)
  );

  me_search_ctrl #(
    .SAD_WIDTH(16), .TB_LENGTH(TB), .SW_LENGTH(SW), .PIPE_DELAY(PD), .TIE_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .abort(abort), .sad(sad), .clr(clr1),
    .en_addr_sw(eas1), .en_addr_tb(eat1), .en_pearray_sw(eps1), .en_pearray_tb(ept1),
    .min_sad(ms1), .min_mvx(mx1), .min_mvy(my1), .cand_cnt(cc1), .aborted(ab1), .ack(ack1)
  );

  me_search_ctrl u_dutl (
    .clk(clk), .rst_n(rst_nl), .req(req_l), .abort(abort_l), .sad(sad_l), .clr(clrl),
    .en_addr_sw(easl), .en_addr_tb(eatl), .en_pearray_sw(epsl), .en_pearray_tb(eptl),
    .min_sad(msl), .min_mvx(mxl), .min_mvy(myl), .cand_cnt(ccl), .aborted(abl), .ack(ackl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One search on the 8/4 pair; abort_at < 0 means no abort.
  task automatic run_small(input int mode, input int abort_at);
    int tab[SW*SW];
    int a, cx, cy, v, cyc, p, e_cc, e_ab;
    int e_ms0, e_mx0, e_my0, e_ms1, e_mx1, e_my1;
    logic exp_ack;
    bit done;
    a    = (abort_at < 0) ? Never : abort_at;
    e_ab = (abort_at < 0) ? 0 : 1;
    for (int i = 0; i < SW * SW; i++) begin
      cx = i / SW - (TB - 1);
      cy = i % SW - (TB - 1);
      if (cx < 0 || cy < 0) tab[i] = int'($urandom_range(0, 65535));
      else begin
        case (mode)
          0:       tab[i] = 100;
          1:       tab[i] = (cx == 2 && cy == 3) ? 50 : 200;
          2:       tab[i] = ((cx == 1 && cy == 1) || (cx == 4 && cy == 4)) ? 40 : 200;
          default: tab[i] = int'($urandom_range(0, 7));
        endcase
      end
    end
    e_ms0 = 'hFFFF; e_mx0 = 0; e_my0 = 0;
    e_ms1 = 'hFFFF; e_mx1 = 0; e_my1 = 0;
    e_cc  = 0;
    for (int x = 0; x < N; x++) begin
      for (int y = 0; y < N; y++) begin
        cyc = PD + 1 + (x + TB - 1) * SW + (y + TB - 1);
        if (cyc < a) begin
          v = tab[(x + TB - 1) * SW + (y + TB - 1)];
          e_cc++;
          if (v < e_ms0) begin e_ms0 = v; e_mx0 = x; e_my0 = y; end
          if (v <= e_ms1) begin e_ms1 = v; e_mx1 = x; e_my1 = y; end
        end
      end
    end

    req = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < PD + SW * SW + 8 && !done; k++) begin
      p = k - (PD + 1);
      if (p >= 0 && p < SW * SW) sad = 16'(tab[p]);
      else                       sad = 16'($urandom_range(0, 65535));
      abort = (k == a);
      chk("en_addr_sw", eas0, k >= 1 && k <= SW * SW && k <= a);
      chk("en_addr_tb", eat0, k >= 1 && k <= TB * TB && k <= a);
      chk("en_pearray_sw", eps0, k >= 2 && k <= SW * SW + SW - TB + 1 && k <= a);
      chk("en_pearray_tb", ept0, k >= 2 && k <= TB * TB + 1 && k <= a);
      chk("clr_run", clr0, 0);
      exp_ack = (abort_at < 0) ? (k >= PD + SW * SW + 2) : (k >= a + 1);
      chk("ack0", ack0, exp_ack);
      chk("ack1", ack1, exp_ack);
      done = exp_ack;
      if (!done) step();
    end
    abort = 1'b0;

    chk("min_sad0", ms0, e_ms0);
    chk("min_mvx0", mx0, e_mx0);
    chk("min_mvy0", my0, e_my0);
    chk("cand_cnt0", cc0, e_cc);
    chk("aborted0", ab0, e_ab);
    chk("min_sad1", ms1, e_ms1);
    chk("min_mvx1", mx1, e_mx1);
    chk("min_mvy1", my1, e_my1);
    chk("cand_cnt1", cc1, e_cc);

    // Abort in DONE must be ignored; req held keeps DONE.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ack_hold", ack0, 1);
    chk("aborted_hold", ab0, e_ab);
    step();
    chk("ack_hold2", ack0, 1);
    req = 1'b0;
    step();
    chk("ack_drop", ack0, 0);
    chk("clr_idle", clr0, 1);
    chk("min_sad_kept", ms0, e_ms0);
    chk("min_mvx_kept", mx0, e_mx0);
    chk("cand_cnt_kept", cc0, e_cc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_ms, e_mx, e_my, v, p, x, y;
    logic exp_ack;
    bit done;
    rst_n = 1'b0; rst_nl = 1'b0; req = 1'b0; req_l = 1'b0;
    abort = 1'b0; abort_l = 1'b0; sad = '0; sad_l = '0;
    #12;
    chk("rst_clr", clr0, 0);
    chk("rst_en_addr_sw", eas0, 0);
    chk("rst_en_addr_tb", eat0, 0);
    chk("rst_en_pearray_sw", eps0, 0);
    chk("rst_en_pearray_tb", ept0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_min_sad", ms0, 16'hFFFF);
    chk("rst_mv", {mx0, my0}, 0);
    chk("rst_cand_cnt", cc0, 0);
    chk("rst_aborted", ab0, 0);
    rst_n = 1'b1;
    rst_nl = 1'b1;
    #1;
    chk("init_clr", clr0, 0);
    step();
    chk("idle_clr", clr0, 1);
    chk("idle_ack", ack0, 0);

    run_small(0, -1);
    run_small(1, -1);
    run_small(2, -1);
    run_small(0, 20);
    run_small(3, 0);
    run_small(3, PD + SW * SW + 1);
    for (int i = 0; i < 3; i++) run_small(3, int'($urandom_range(1, PD + SW * SW)));
    run_small(3, -1);
    run_small(3, -1);

    // Default-size controller: reset mid-run, then a full search.
    req_l = 1'b1;
    step();
    for (int k = 0; k < 1500; k++) begin
      sad_l = 16'($urandom_range(0, 65535));
      step();
    end
    rst_nl = 1'b0;
    #1;
    chk("L_rst_en_addr_sw", easl, 0);
    chk("L_rst_en_pearray_sw", epsl, 0);
    chk("L_rst_ack", ackl, 0);
    chk("L_rst_clr", clrl, 0);
    chk("L_rst_min_sad", msl, 16'hFFFF);
    chk("L_rst_cand_cnt", ccl, 0);
    req_l = 1'b0;
    #2;
    rst_nl = 1'b1;
    step();
    chk("L_idle_clr", clrl, 1);

    for (int i = 0; i < SWL * SWL; i++) begin
      if (i / SWL >= TBL - 1 && i % SWL >= TBL - 1) tab_l[i] = int'($urandom_range(0, 4095));
      else                                          tab_l[i] = int'($urandom_range(0, 65535));
    end
    e_ms = 'hFFFF; e_mx = 0; e_my = 0;
    for (int cxl = 0; cxl < NL; cxl++) begin
      for (int cyl = 0; cyl < NL; cyl++) begin
        x = cxl + TBL - 1;
        y = cyl + TBL - 1;
        v = tab_l[x * SWL + y];
        if (v < e_ms) begin e_ms = v; e_mx = cxl; e_my = cyl; end
      end
    end
    req_l = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < PDL + SWL * SWL + 8 && !done; k++) begin
      p = k - (PDL + 1);
      if (p >= 0 && p < SWL * SWL) sad_l = 16'(tab_l[p]);
      else                         sad_l = 16'($urandom_range(0, 65535));
      if (k == 1) chk("L_en_addr_sw_on", easl, 1);
      exp_ack = (k >= PDL + SWL * SWL + 2);
      chk("L_ack", ackl, exp_ack);
      done = exp_ack;
      if (!done) step();
    end
    chk("L_min_sad", msl, e_ms);
    chk("L_min_mvx", mxl, e_mx);
    chk("L_min_mvy", myl, e_my);
    chk("L_cand_cnt", ccl, NL * NL);
    chk("L_aborted", abl, 0);
    req_l = 1'b0;
    step();
    chk("L_ack_drop", ackl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
